// File: rtl/ext_ram_arb_pkg.sv
// Shared types and helpers for the external RAM arbiter.
package ext_ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef enum logic {
    GNT_INSTR,
    GNT_DATA
  } grant_t;

  // Width of the wait-state counter; it holds WAIT_CYCLES values up to 15.
  localparam int WAIT_W = 4;

  // Each enabled lane comes from new_word; every other lane keeps old_word.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) merged[8*k +: 8] = new_word[8*k +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/ram_byte_merge.sv
// Combinational lane merge used to build the read-merge-write word.
module ram_byte_merge
  import ext_ram_arb_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  be,
  output logic [31:0] merged
);

  assign merged = byte_merge(old_word, new_word, be);

endmodule

// File: rtl/ext_ram_arbiter.sv
// Round-robin arbiter sharing one word-wide external RAM between the CPU
// instruction and data masters, with programmable wait states and
// read-merge-write for partial-byte stores.
module ext_ram_arbiter
  import ext_ram_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_read,
  output logic              i_waitrequest,
  output logic [31:0]       i_readdata,
  input  logic [ADDR_W-1:0] d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [3:0]        d_byteenable,
  input  logic [31:0]       d_writedata,
  output logic              d_waitrequest,
  output logic [31:0]       d_readdata,
  output logic [31:0]       ram_addr,
  output logic [31:0]       ram_write_data,
  output logic              ram_wen,
  input  logic [31:0]       ram_data_out
);

  state_t             state, state_next;
  grant_t             last_grant, grant_q, grant_next;
  logic [WAIT_W-1:0]  count;
  logic [ADDR_W-1:2]  addr_q;
  logic               write_q;
  logic [3:0]         be_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic [31:0]        merged;
  logic               start;
  logic               req_d;
  logic               last_access;

  // The RAM is word addressed, so the byte offset bits are simply dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_address[1:0], d_address[1:0]};

  assign req_d       = d_read | d_write;
  assign last_access = (state == ACCESS) && (count == WAIT_W'(1));
  assign ram_addr    = 32'(addr_q);

  ram_byte_merge u_merge (
    .old_word (rdata_q),
    .new_word (wdata_q),
    .be       (be_q),
    .merged   (merged)
  );

  // Round-robin choice: on a tie, the port that did not win last time.
  always_comb begin
    grant_next = GNT_INSTR;
    if (i_read && req_d) begin
      grant_next = (last_grant == GNT_INSTR) ? GNT_DATA : GNT_INSTR;
    end else if (req_d) begin
      grant_next = GNT_DATA;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic and the per-state port/RAM strobes.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would infer a latch.
    state_next     = state;
    start          = 1'b0;
    i_waitrequest  = 1'b1;
    d_waitrequest  = 1'b1;
    ram_wen        = 1'b0;
    ram_write_data = '0;
    case (state)
      IDLE: begin
        if (i_read || req_d) begin
          start      = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (last_access) state_next = RESP;
      end
      RESP: begin
        state_next = IDLE;
        if (grant_q == GNT_INSTR) i_waitrequest = 1'b0;
        else                      d_waitrequest = 1'b0;
        // A zero byteenable still completes the transaction but leaves RAM alone.
        if (write_q && (be_q != 4'b0000)) begin
          ram_wen        = 1'b1;
          ram_write_data = merged;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture, wait-state counter and read data registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= GNT_DATA;
      grant_q    <= GNT_INSTR;
      count      <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      i_readdata <= '0;
      d_readdata <= '0;
    end else if (start) begin
      grant_q    <= grant_next;
      last_grant <= grant_next;
      addr_q     <= (grant_next == GNT_INSTR) ? i_address[ADDR_W-1:2]
                                              : d_address[ADDR_W-1:2];
      // Read and write together counts as a write.
      write_q    <= (grant_next == GNT_DATA) && d_write;
      be_q       <= d_byteenable;
      wdata_q    <= d_writedata;
      count      <= WAIT_W'(WAIT_CYCLES);
    end else if (state == ACCESS) begin
      count <= count - WAIT_W'(1);
      if (last_access) begin
        rdata_q <= ram_data_out;
        // Load the granted port's readdata now so it is valid during RESP;
        // the other port keeps its last value.
        if (!write_q) begin
          if (grant_q == GNT_INSTR) i_readdata <= ram_data_out;
          else                      d_readdata <= ram_data_out;
        end
      end
    end
  end

endmodule

// File: doc/ext_ram_arbiter.md
Name: ext_ram_arbiter

Overview:
- Shares the single-port word-addressed external RAM between the CPU instruction master (read-only) and data master (read/write with byte enables).
- Both masters face Avalon-style ports with waitrequest; the RAM faces a combinational-read, clocked-write port.
- Inserts programmable wait states to model slow memory.
- Turns partial-byte writes into a read-merge-write, because the RAM stores whole words only.

Parameters:
- WAIT_CYCLES, 2, number of ACCESS cycles per transaction; legal range 1..15.
- ADDR_W, 32, byte-address width of the master ports.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_address  in  ADDR_W  instruction byte address.
- i_read  in  1  instruction read request.
- i_waitrequest  out  1  instruction stall.
- i_readdata  out  32  instruction read data.
- d_address  in  ADDR_W  data byte address.
- d_read  in  1  data read request.
- d_write  in  1  data write request.
- d_byteenable  in  4  data byte lanes; bit k covers bits [8k+7:8k].
- d_writedata  in  32  data write data.
- d_waitrequest  out  1  data stall.
- d_readdata  out  32  data read data.
- ram_addr  out  32  RAM word address.
- ram_write_data  out  32  RAM write data.
- ram_wen  out  1  RAM write enable.
- ram_data_out  in  32  RAM combinational read data.

Behaviour:
- Reset (async, reset_n=0) gives state=IDLE, counter=0, last_grant=DATA, i_waitrequest=1, d_waitrequest=1, ram_wen=0, ram_addr=0, ram_write_data=0, both readdata outputs=0.
- waitrequest is 1 in every cycle except a port's own RESP cycle. Masters must hold request signals stable while waitrequest=1.
- ram_addr = {2'b00, captured_address[31:2]}. The low 2 address bits are ignored; no misalignment error is raised.
- IDLE:
  - If exactly one port requests, grant it.
  - If both request, grant the port that is not last_grant (round-robin). After reset the instruction port wins the first tie.
  - On grant, capture address, op, byteenable and writedata into registers, update last_grant, load counter=WAIT_CYCLES, go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - Drive ram_addr from the captured address; decrement the counter.
  - In the last ACCESS cycle (counter=1), register ram_data_out into rdata_q, then go to RESP.
- RESP (one cycle):
  - Granted port's waitrequest=0.
  - Read: granted readdata=rdata_q; the other port's readdata holds its last value.
  - Write with byteenable=4'b1111: ram_wen=1, ram_write_data=d_writedata captured.
  - Write with partial byteenable: ram_wen=1, ram_write_data=merge(rdata_q, wdata, be), where each enabled lane comes from wdata and each other lane from rdata_q.
  - Write with byteenable=4'b0000: ram_wen=0; still completes normally.
  - Next state is always IDLE.
- Latency: request present in IDLE cycle N gives RESP at cycle N+WAIT_CYCLES+1. Throughput is one transaction per WAIT_CYCLES+2 cycles.
- d_read and d_write both high is treated as a write.
- A request dropped mid-transaction still runs to RESP, including the RAM write; the RESP pulse is issued regardless.
- ram_wen is asserted only in RESP, never in IDLE or ACCESS.
- Reset asserted mid-transaction aborts immediately: no ram_wen pulse and no RESP.

Decomposition:
- Package ext_ram_arb_pkg holds:
  - state enum {IDLE, ACCESS, RESP};
  - grant enum {GNT_INSTR, GNT_DATA};
  - WAIT_W=4 constant;
  - byte_merge(old, new, be) function.
- Sub-module ram_byte_merge: combinational lane merge, instantiated once.
- FSM, counter and arbitration stay in ext_ram_arbiter.

Test Plan:
- Instruction read (WAIT_CYCLES=2, RAM word 0x100=0xDEADBEEF), i_read=1 with i_address=0x400 at cycle 0 -> i_waitrequest=0 and i_readdata=0xDEADBEEF at cycle 3 only; ram_wen stays 0.
- Full data write, d_write=1, d_address=0x10, be=4'b1111, data=0x12345678 -> ram_wen=1 only at cycle 3 with ram_addr=0x4; a following read of 0x10 returns 0x12345678.
- Partial write, RAM word 0x4=0xAABBCCDD, be=4'b0101, data=0x11223344 -> ram_write_data=0xAA22CC44 in RESP.
- Simultaneous i_read and d_read, both held -> instruction served first (RESP cycle 3), data served next (RESP cycle 7). Repeat the tie -> data first, instruction second.
- Zero byteenable write -> d_waitrequest pulses low at cycle 3 and ram_wen never rises.
- Assert reset_n=0 during ACCESS of a write -> outputs return to reset values immediately, ram_wen never rises, and a new read after release completes with normal latency.
